// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serializer.
// Line outputs are registered from the current FSM state, so they lag it by one cycle.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int UART_BAUD  = 9600,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  ICE_CLK,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_byte,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx
);

  localparam int CPB   = CLK_FREQ / UART_BAUD;
  localparam int CW    = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CW-1:0]         CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   Q_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] P_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  ovf_q;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            mem_q [DEPTH];

  logic push, pop, bit_end;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = (state_q == S_IDLE) && !empty;
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge ICE_CLK) begin
    if (!rst && push) mem_q[wptr_q] <= wr_byte;
  end

  always_ff @(posedge ICE_CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (push) wptr_q <= wptr_q + P_ONE;
      if (pop)  rptr_q <= rptr_q + P_ONE;
      if (push && !pop)      count_q <= count_q + Q_ONE;
      else if (pop && !push) count_q <= count_q - Q_ONE;
      if (wr_en && full) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (pop) begin
          shift_d = mem_q[rptr_q];
          state_d = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: if (bit_end) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != S_IDLE);
    done_d = (state_q == S_STOP) && bit_end;
    unique case (state_q)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      S_STOP:  tx_d = 1'b1;
    endcase
  end

  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: CPB=16, 4-deep FIFO.
// Frames are decoded by sampling tx mid-bit.
module tb_uart_tx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       full, empty, overflow, busy, tx_done, tx;
  logic [2:0] count;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (160),
    .UART_BAUD (10),
    .DEPTH_LOG2(2)
  ) u_dut (
    .ICE_CLK (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_byte (wr_byte),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .busy    (busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_byte = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_byte = 8'hAA;
    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic rx(output logic [7:0] b, output int t0);
    int n = 0;
    b  = 8'h00;
    t0 = -1;
    while (tx !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    if (tx !== 1'b0) begin
      chk("start_seen", 0, 1);
      return;
    end
    t0 = cyc;
    repeat (CPB/2) tick();
    chk("start_bit", tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = tx;
    end
    repeat (CPB) tick();
    chk("stop_bit", tx, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic quiet(input int n, input string tag);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    chk(tag, lows, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int t0, t1, t2;
    logic [7:0] fb [5];

    do_reset();
    quiet(40, "rst_no_frame");

    // single byte 0x55
    put(8'h55);
    chk("lat_count1", count, 1);
    chk("lat_empty0", empty, 0);
    chk("lat_tx_hi1", tx, 1);
    tick();
    chk("pop_count0", count, 0);
    chk("pop_tx_hi", tx, 1);
    chk("pop_busy0", busy, 0);
    tick();
    chk("lat_tx_lo", tx, 0);
    chk("lat_busy1", busy, 1);
    rx(b, t0);
    chk("single_byte", b, 8'h55);
    repeat (6) tick();
    chk("done_early", tx_done, 0);
    tick();
    chk("done_pulse", tx_done, 1);
    chk("done_busy", busy, 1);
    tick();
    chk("done_clear", tx_done, 0);
    chk("busy_drop", busy, 0);

    // burst
    do_reset();
    put(8'hA5);
    put(8'h00);
    put(8'hFF);
    chk("burst_count", count, 2);
    rx(b, t0);
    chk("burst_b0", b, 8'hA5);
    rx(b, t1);
    chk("burst_b1", b, 8'h00);
    rx(b, t2);
    chk("burst_b2", b, 8'hFF);
    chk("burst_gap01", t1 - t0, 161);
    chk("burst_gap12", t2 - t1, 161);
    wait_idle();

    // full / overflow
    do_reset();
    for (int i = 0; i < 5; i++) put(8'h10 + 8'(i));
    chk("full_set", full, 1);
    chk("full_count", count, 4);
    chk("ovf_before", overflow, 0);
    put(8'h15);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    for (int i = 0; i < 5; i++) rx(fb[i], t0);
    for (int i = 0; i < 5; i++) chk($sformatf("ovf_frame%0d", i), fb[i], 8'h10 + 8'(i));
    chk("ovf_empty", empty, 1);
    wait_idle();
    quiet(300, "ovf_no_6th");
    chk("ovf_sticky", overflow, 1);

    // wrap-around streaming
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          int w = 0;
          while (full && w < 5000) begin
            tick();
            w++;
          end
          put(8'(i));
        end
      end
      begin
        int errs = 0;
        logic [7:0] rb;
        int rt;
        for (int i = 0; i < 20; i++) begin
          rx(rb, rt);
          if (rb !== 8'(i)) errs++;
        end
        chk("wrap_order_errs", errs, 0);
      end
    join
    wait_idle();
    chk("wrap_empty", empty, 1);
    chk("wrap_no_ovf", overflow, 0);

    // reset mid-frame
    do_reset();
    put(8'hF0);
    put(8'h11);
    put(8'h22);
    chk("mid_count", count, 2);
    chk("mid_tx_lo", tx, 0);
    repeat (CPB*4 + CPB/2) tick();
    chk("mid_bit3", tx, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_empty", empty, 1);
    rst = 1'b0;
    quiet(400, "mid_no_frame");
    put(8'h3C);
    rx(b, t0);
    chk("post_rst_byte", b, 8'h3C);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter: bytes are written into an internal FIFO and serialized LSB-first on the TX line at a fixed baud rate. It is the transmit-side counterpart to the UART receive path feeding RAM, and lets upstream logic dump bursts of bytes without waiting on the serializer. It sits between byte-producing logic (RAM readers, command responders) and the board's UART_TX pin.

## Interface

Parameters:
- CLK_FREQ, 12000000, ICE_CLK frequency in Hz.
- UART_BAUD, 9600, line rate in baud. CPB = CLK_FREQ / UART_BAUD (integer division), clocks per bit; CPB must be at least 2.
- DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 bytes.

Ports:
- ICE_CLK  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write strobe; accepted when full=0.
- wr_byte  in  8  byte to enqueue.
- full  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  DEPTH_LOG2+1  bytes currently queued, excluding the byte being sent.
- overflow  out  1  sticky; set when wr_en=1 while full=1. Cleared only by rst.
- busy  out  1  serializer not in IDLE.
- tx_done  out  1  one-cycle pulse in the last cycle of each stop bit.
- tx  out  1  serial line, idle high.

## Operation

- FIFO: circular buffer, DEPTH_LOG2-bit read and write pointers wrapping modulo depth, plus a (DEPTH_LOG2+1)-bit count register. full and empty are decoded from the registered count.
- Write: if wr_en=1 and full=0, store wr_byte at wptr, then increment wptr. If full=1, drop the byte, set overflow, and leave pointers unchanged. A pop in the same cycle does not rescue a write made while full.
- Pop: occurs only in IDLE with empty=0. Load the shift register from rptr and increment rptr.
- A write and a pop in the same cycle leave count unchanged; both happen.
- FSM states:
  - IDLE: tx=1, busy=0. If empty=0, pop and go to START.
  - START: tx=0 for CPB cycles, then go to DATA.
  - DATA: tx=shift[0] for CPB cycles per bit, shifting right; bit index 0..7. After bit 7 go to STOP.
  - STOP: tx=1 for CPB cycles. tx_done=1 in the final cycle, then go to IDLE.
- Baud counter: counts 0..CPB-1 and is reset to 0 on every state or bit change. All counters are sized to hold CPB-1 without overflow.
- tx, busy and tx_done are registered outputs, so tx has no glitches.
- Reset (at any time, including mid-frame):
  - next edge gives tx=1, busy=0, tx_done=0, count=0, empty=1, full=0, overflow=0, and FSM in IDLE;
  - pointers go to 0;
  - queued and in-flight bytes are discarded;
  - wr_en is ignored in the reset cycle.

## Timing

- Empty-FIFO latency:
  - wr_en sampled at edge N gives count=1 and empty=0 after N;
  - pop at edge N+1;
  - tx falls after edge N+2, i.e. two cycles after the accepting edge.
- Frame: start + 8 data + stop = 10·CPB cycles of tx activity.
- After STOP the FSM spends exactly one cycle in IDLE, where it pops if data is queued. Back-to-back start-bit falling edges are 10·CPB+1 cycles apart.
- busy is high from the cycle after the pop through the last stop-bit cycle.
- tx_done coincides with that last stop-bit cycle.
- count decrements on the edge following the pop and increments on the edge following an accepted write.
- Throughput: writes are accepted every cycle while full=0. Sustained drain is one byte per 10·CPB+1 cycles.

## Test plan

All scenarios use CLK_FREQ=160, UART_BAUD=10, so CPB=16.

- Reset: hold rst 3 cycles with wr_en=1 -> tx=1, empty=1, count=0, busy=0, overflow=0. No frame appears.
- Single byte: write 0x55 -> tx low 2 cycles later for 16 cycles, then bits 1,0,1,0,1,0,1,0 (16 cycles each), then stop high. tx_done pulses at cycle 160 of the frame. busy drops afterwards.
- Burst: write 0xA5, 0x00, 0xFF on consecutive cycles -> count peaks at 2. A bench UART decoder sees 0xA5, 0x00, 0xFF in order. Start edges are 161 cycles apart.
- Full/overflow with DEPTH_LOG2=2: write 6 bytes back-to-back from reset -> the first pops, 4 are queued, full=1, the 6th is dropped, and overflow=1 stays set. Five frames total are emitted.
- Wrap-around: with DEPTH_LOG2=2, stream 20 sequential bytes 0x00..0x13, gating writes on full=0 -> all 20 decoded in order. empty=1 at the end.
- Reset mid-frame: assert rst during data bit 3 of 0xF0 with 2 bytes queued -> tx=1 at the next edge, count=0, and no further frames appear. A subsequent write of 0x3C transmits correctly.
